// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: operand forwarding,
// load-use stalls, taken-branch flush sequencing and data-memory freeze.
module pipeline_ctrl #(
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             de_valid_i,
  input  logic [3:0]       de_rn_addr_i,
  input  logic [3:0]       de_rm_addr_i,
  input  logic             de_use_rn_i,
  input  logic             de_use_rm_i,
  input  logic             ex_valid_i,
  input  logic [3:0]       ex_rd_addr_i,
  input  logic             ex_load_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_valid_i,
  input  logic [3:0]       mem_rd_addr_i,
  input  logic             mem_write_i,
  input  logic             mem_busy_i,
  input  logic             wb_en_i,
  input  logic [3:0]       wb_addr_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_fe_o,
  output logic             stall_de_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             bubble_ex_o,
  output logic             flush_fe_o,
  output logic             flush_de_o,
  output logic             redirect_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned FC_W = 3;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MEMWAIT = 2'b10,
    FLUSH   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use;
  logic             branch_ev;
  logic             run_path;

  // Newest producer wins; R15 (PC) is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [3:0] x,
                                         input logic       mv,
                                         input logic       mw,
                                         input logic [3:0] ma,
                                         input logic       we,
                                         input logic [3:0] wa);
    logic [1:0] sel;
    sel = 2'b00;
    if (x != 4'hF) begin
      if (mv && mw && ma == x)  sel = 2'b01;
      else if (we && wa == x)   sel = 2'b10;
    end
    return sel;
  endfunction

  assign load_use = de_valid_i && ex_valid_i && ex_load_i &&
                    ((de_use_rn_i && de_rn_addr_i == ex_rd_addr_i) ||
                     (de_use_rm_i && de_rm_addr_i == ex_rd_addr_i));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_fe_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (branch_ev && !(&flush_cnt_q))  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    branch_ev   = 1'b0;
    run_path    = 1'b0;
    fwd_a_o     = fwd_sel(de_rn_addr_i, mem_valid_i, mem_write_i, mem_rd_addr_i,
                          wb_en_i, wb_addr_i);
    fwd_b_o     = fwd_sel(de_rm_addr_i, mem_valid_i, mem_write_i, mem_rd_addr_i,
                          wb_en_i, wb_addr_i);
    stall_fe_o  = 1'b0;
    stall_de_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    bubble_ex_o = 1'b0;
    flush_fe_o  = 1'b0;
    flush_de_o  = 1'b0;
    redirect_o  = 1'b0;

    unique case (state_q)
      RUN: run_path = 1'b1;
      LDSTALL: begin
        if (mem_busy_i) begin
          {stall_fe_o, stall_de_o, stall_ex_o, stall_mem_o} = 4'b1111;
          state_d = MEMWAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEMWAIT: begin
        if (mem_busy_i) {stall_fe_o, stall_de_o, stall_ex_o, stall_mem_o} = 4'b1111;
        else            run_path = 1'b1;
      end
      FLUSH: begin
        // Execute holds a bubble here, so a taken-branch flag is stale.
        flush_fe_o = 1'b1;
        flush_de_o = 1'b1;
        if (mem_busy_i)              {stall_fe_o, stall_de_o, stall_ex_o, stall_mem_o} = 4'b1111;
        else if (fcnt_q == '0)       state_d = RUN;
        else                         fcnt_d = fcnt_q - FC_W'(1);
      end
      default: state_d = RUN;
    endcase

    if (run_path) begin
      state_d = RUN;
      if (ex_valid_i && ex_branch_taken_i) begin
        redirect_o = 1'b1;
        flush_fe_o = 1'b1;
        flush_de_o = 1'b1;
        branch_ev  = 1'b1;
        if (FETCH_LAT != 0) begin
          state_d = FLUSH;
          fcnt_d  = FC_W'(FETCH_LAT - 1);
        end
      end else if (mem_busy_i) begin
        {stall_fe_o, stall_de_o, stall_ex_o, stall_mem_o} = 4'b1111;
        state_d = MEMWAIT;
      end else if (load_use) begin
        stall_fe_o  = 1'b1;
        stall_de_o  = 1'b1;
        bubble_ex_o = 1'b1;
        state_d     = LDSTALL;
      end
    end

    // Reset forces a flushed, non-stalled pipe regardless of state.
    if (!reset_n_i) begin
      fwd_a_o     = 2'b00;
      fwd_b_o     = 2'b00;
      stall_fe_o  = 1'b0;
      stall_de_o  = 1'b0;
      stall_ex_o  = 1'b0;
      stall_mem_o = 1'b0;
      bubble_ex_o = 1'b1;
      flush_fe_o  = 1'b1;
      flush_de_o  = 1'b1;
      redirect_o  = 1'b0;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table plus hand sequences for
// load-use, branch flush, memory freeze, reset abort and counter saturation.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic       rst_n;
    logic       dv;
    logic [3:0] rn, rm;
    logic       urn, urm;
    logic       exv;
    logic [3:0] exrd;
    logic       exld, exbr;
    logic       mv;
    logic [3:0] mrd;
    logic       mw, busy, wbe;
    logic [3:0] wba;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic [3:0] st;
    logic       bub, ffe, fde, red;
    logic [1:0] state;
  } out_t;

  typedef struct {
    in_t   in;
    out_t  exp;
    string name;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, de_valid, de_use_rn, de_use_rm, ex_valid, ex_load, ex_br;
  logic mem_valid, mem_write, mem_busy, wb_en;
  logic [3:0] de_rn, de_rm, ex_rd, mem_rd, wb_addr;
  logic [1:0] fwd_a, fwd_b, state;
  logic stall_fe, stall_de, stall_ex, stall_mem, bubble_ex, flush_fe, flush_de, redirect;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.FETCH_LAT(2), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .de_valid_i(de_valid), .de_rn_addr_i(de_rn), .de_rm_addr_i(de_rm),
    .de_use_rn_i(de_use_rn), .de_use_rm_i(de_use_rm),
    .ex_valid_i(ex_valid), .ex_rd_addr_i(ex_rd), .ex_load_i(ex_load),
    .ex_branch_taken_i(ex_br),
    .mem_valid_i(mem_valid), .mem_rd_addr_i(mem_rd), .mem_write_i(mem_write),
    .mem_busy_i(mem_busy), .wb_en_i(wb_en), .wb_addr_i(wb_addr),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .stall_fe_o(stall_fe), .stall_de_o(stall_de), .stall_ex_o(stall_ex),
    .stall_mem_o(stall_mem), .bubble_ex_o(bubble_ex),
    .flush_fe_o(flush_fe), .flush_de_o(flush_de), .redirect_o(redirect),
    .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  int passed = 0;
  int total  = 0;
  vec_t sb[$];
  vec_t tbl[$];

  function automatic in_t mk(logic dv, logic [3:0] rn, logic [3:0] rm, logic urn, logic urm,
                             logic exv, logic [3:0] exrd, logic exld, logic exbr,
                             logic mv, logic [3:0] mrd, logic mw, logic busy,
                             logic wbe, logic [3:0] wba);
    in_t v;
    v = '{rst_n: 1'b1, dv: dv, rn: rn, rm: rm, urn: urn, urm: urm, exv: exv, exrd: exrd,
          exld: exld, exbr: exbr, mv: mv, mrd: mrd, mw: mw, busy: busy, wbe: wbe, wba: wba};
    return v;
  endfunction

  function automatic out_t o(logic [1:0] fa, logic [1:0] fb, logic [3:0] st, logic bub,
                             logic ffe, logic fde, logic red, logic [1:0] s);
    out_t r;
    r = '{fa: fa, fb: fb, st: st, bub: bub, ffe: ffe, fde: fde, red: red, state: s};
    return r;
  endfunction

  // Drive one cycle just after the edge; the monitor checks it at the falling edge.
  task automatic step(input in_t v, input out_t e, input string nm);
    vec_t t;
    reset_n = v.rst_n; de_valid = v.dv; de_rn = v.rn; de_rm = v.rm;
    de_use_rn = v.urn; de_use_rm = v.urm; ex_valid = v.exv; ex_rd = v.exrd;
    ex_load = v.exld; ex_br = v.exbr; mem_valid = v.mv; mem_rd = v.mrd;
    mem_write = v.mw; mem_busy = v.busy; wb_en = v.wbe; wb_addr = v.wba;
    t.in = v; t.exp = e; t.name = nm;
    sb.push_back(t);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t t;
      out_t a;
      t = sb.pop_front();
      a = '{fa: fwd_a, fb: fwd_b, st: {stall_fe, stall_de, stall_ex, stall_mem},
            bub: bubble_ex, ffe: flush_fe, fde: flush_de, red: redirect, state: state};
      total++;
      if (a === t.exp) passed++;
      else $display("FAIL %s: got fa=%b fb=%b st=%b bub=%b ffe=%b fde=%b red=%b state=%b, expected fa=%b fb=%b st=%b bub=%b ffe=%b fde=%b red=%b state=%b",
                    t.name, a.fa, a.fb, a.st, a.bub, a.ffe, a.fde, a.red, a.state,
                    t.exp.fa, t.exp.fb, t.exp.st, t.exp.bub, t.exp.ffe, t.exp.fde, t.exp.red, t.exp.state);
    end
  end

  task automatic chk_cnt(input string nm, input int es, input int ef);
    total++;
    if (stall_cnt === CNT_W'(es) && flush_cnt === CNT_W'(ef)) passed++;
    else $display("FAIL %s: got stall_cnt=%0d flush_cnt=%0d, expected %0d %0d",
                  nm, stall_cnt, flush_cnt, es, ef);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_t idle, lu, lu_b, lu_mem, br, br_b, busy, rst;
    out_t z;
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu     = mk(1, 7, 2, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    lu_b   = mk(1, 7, 2, 0, 1, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0);
    lu_mem = mk(1, 7, 2, 0, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
    br     = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    br_b   = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    busy   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    z      = o(2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b00);

    rst = mk(0, 3, 3, 1, 1, 0, 0, 0, 0, 1, 3, 1, 1, 1, 3);
    rst.rst_n = 1'b0;
    reset_n = 1'b0;
    {de_valid, de_use_rn, de_use_rm, ex_valid, ex_load, ex_br} = '0;
    {mem_valid, mem_write, mem_busy, wb_en} = '0;
    {de_rn, de_rm, ex_rd, mem_rd, wb_addr} = '0;
    @(posedge clk);
    #1;
    step(rst, o(2'b00, 2'b00, 4'b0000, 1, 1, 1, 0, 2'b00), "reset_force");
    chk_cnt("reset_cnt", 0, 0);

    tbl.push_back('{mk(0, 3, 0, 1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 1, 3), o(2'b01, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b00), "fwd_mem"});
    tbl.push_back('{mk(0, 3, 0, 1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 1, 3), o(2'b10, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b00), "fwd_wb"});
    tbl.push_back('{mk(0, 15, 15, 1, 1, 0, 0, 0, 0, 1, 15, 1, 0, 1, 15), z, "fwd_r15"});
    tbl.push_back('{mk(0, 4, 5, 1, 1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 4), o(2'b10, 2'b01, 4'b0000, 0, 0, 0, 0, 2'b00), "fwd_split"});
    tbl.push_back('{mk(0, 4, 4, 1, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0), z, "fwd_mem_invalid"});
    tbl.push_back('{lu, o(2'b00, 2'b00, 4'b1100, 1, 0, 0, 0, 2'b00), "lu_rm"});
    tbl.push_back('{lu_mem, o(2'b00, 2'b01, 4'b0000, 0, 0, 0, 0, 2'b01), "lu_ldstall"});
    tbl.push_back('{lu_mem, o(2'b00, 2'b01, 4'b0000, 0, 0, 0, 0, 2'b00), "lu_resume"});
    tbl.push_back('{mk(1, 6, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0), z, "lu_no_use"});
    tbl.push_back('{mk(0, 6, 6, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0), z, "lu_de_invalid"});
    tbl.push_back('{mk(1, 6, 6, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0), z, "lu_not_load"});
    tbl.push_back('{mk(1, 9, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0), o(2'b00, 2'b00, 4'b1100, 1, 0, 0, 0, 2'b00), "lu_rn"});
    tbl.push_back('{idle, o(2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b01), "lu_rn_ldstall"});
    for (int i = 0; i < tbl.size(); i++) step(tbl[i].in, tbl[i].exp, tbl[i].name);
    chk_cnt("cnt_after_table", 2, 0);

    // Busy for three cycles with a pending load-use, bubble on the release cycle.
    step(lu_b, o(2'b00, 2'b00, 4'b1111, 0, 0, 0, 0, 2'b00), "busy_lu_c1");
    step(lu_b, o(2'b00, 2'b00, 4'b1111, 0, 0, 0, 0, 2'b10), "busy_lu_c2");
    step(lu_b, o(2'b00, 2'b00, 4'b1111, 0, 0, 0, 0, 2'b10), "busy_lu_c3");
    step(lu,   o(2'b00, 2'b00, 4'b1100, 1, 0, 0, 0, 2'b10), "busy_lu_release");
    step(lu_mem, o(2'b00, 2'b01, 4'b0000, 0, 0, 0, 0, 2'b01), "busy_lu_ldstall");
    step(idle, z, "busy_lu_run");
    chk_cnt("cnt_busy_lu", 6, 0);

    // Taken branch with a two-cycle fetch latency.
    step(br, o(2'b00, 2'b00, 4'b0000, 0, 1, 1, 1, 2'b00), "br_T");
    chk_cnt("cnt_br", 6, 1);
    step(br,   o(2'b00, 2'b00, 4'b0000, 0, 1, 1, 0, 2'b11), "br_T1_ignored");
    step(idle, o(2'b00, 2'b00, 4'b0000, 0, 1, 1, 0, 2'b11), "br_T2");
    step(idle, z, "br_T3_run");

    // Memory goes busy during the single LDSTALL cycle.
    step(lu,   o(2'b00, 2'b00, 4'b1100, 1, 0, 0, 0, 2'b00), "ldb_lu");
    step(lu_b, o(2'b00, 2'b00, 4'b1111, 0, 0, 0, 0, 2'b01), "ldb_busy");
    step(idle, o(2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b10), "ldb_release");
    step(idle, z, "ldb_run");
    chk_cnt("cnt_ldb", 8, 1);

    // Branch held during MEMWAIT, then busy freezing the flush countdown.
    step(busy, o(2'b00, 2'b00, 4'b1111, 0, 0, 0, 0, 2'b00), "mwb_enter");
    step(br_b, o(2'b00, 2'b00, 4'b1111, 0, 0, 0, 0, 2'b10), "mwb_br_held");
    step(br,   o(2'b00, 2'b00, 4'b0000, 0, 1, 1, 1, 2'b10), "mwb_redirect");
    step(busy, o(2'b00, 2'b00, 4'b1111, 0, 1, 1, 0, 2'b11), "mwb_flush_busy1");
    step(busy, o(2'b00, 2'b00, 4'b1111, 0, 1, 1, 0, 2'b11), "mwb_flush_busy2");
    step(idle, o(2'b00, 2'b00, 4'b0000, 0, 1, 1, 0, 2'b11), "mwb_flush_c1");
    step(idle, o(2'b00, 2'b00, 4'b0000, 0, 1, 1, 0, 2'b11), "mwb_flush_c0");
    step(idle, z, "mwb_run");
    step(br_b, o(2'b00, 2'b00, 4'b0000, 0, 1, 1, 1, 2'b00), "run_br_over_busy");
    step(idle, o(2'b00, 2'b00, 4'b0000, 0, 1, 1, 0, 2'b11), "rbb_flush1");
    step(idle, o(2'b00, 2'b00, 4'b0000, 0, 1, 1, 0, 2'b11), "rbb_flush0");
    step(idle, z, "rbb_run");
    chk_cnt("cnt_mwb", 12, 3);

    // Reset abandons a flush in progress.
    step(br, o(2'b00, 2'b00, 4'b0000, 0, 1, 1, 1, 2'b00), "rst_br");
    step(rst, o(2'b00, 2'b00, 4'b0000, 1, 1, 1, 0, 2'b11), "rst_mid_flush");
    chk_cnt("cnt_rst", 0, 0);
    step(idle, z, "rst_release");

    // Stall counter saturates instead of wrapping.
    step(busy, o(2'b00, 2'b00, 4'b1111, 0, 0, 0, 0, 2'b00), "sat_enter");
    for (int i = 0; i < 19; i++) step(busy, o(2'b00, 2'b00, 4'b1111, 0, 0, 0, 0, 2'b10), "sat_busy");
    chk_cnt("cnt_sat", 15, 0);
    step(idle, o(2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b10), "sat_release");
    step(idle, z, "sat_run");
    chk_cnt("cnt_sat_hold", 15, 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
